obstacle_row_feeder: RTL and testbench
======================================

# obstacle_row_feeder

Serial pattern source for the obstacle lane. Sits directly upstream of the `shifterbitNL` chain and downstream of the `RDF` rate divider. Each rising edge of the divider's slow square wave emits one bit on `serial_out` with a one-cycle `shift_pulse`, which drives the chain's `IN`/`SHIFT`. Patterns come from an 8-bit LFSR: WIDTH pattern bits are emitted, followed by GAP zero bits, and the cycle repeats.

## Interface
Parameters:
- `WIDTH`, default 7: pattern bits per row, legal range 1..8.
- `GAP`, default 4: zero bits emitted after each pattern, legal range 0..15.
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `INPUTCLOCK`, in, 1: the single system clock; all state changes on its rising edge.
- `reset_n`, in, 1: asynchronous, active-high reset; asserted at 1 despite the suffix.
- `run`, in, 1: 1 lets ticks advance the block; 0 freezes all state except the tick sampler.
- `tick_level`, in, 1: slow square wave from `RDF.clkout`, synchronous to `INPUTCLOCK`.
- `serial_out`, out, 1: bit for the shifter's `IN`; valid whenever `shift_pulse`=1.
- `shift_pulse`, out, 1: one-cycle strobe for the shifter's `SHIFT`.
- `load_pulse`, out, 1: one-cycle strobe when a new pattern is taken from the LFSR.
- `pattern`, out, WIDTH: the pattern currently being emitted.
- `rows_fed`, out, 7: completed pattern+gap rows, mod 128.

## Operation
- Tick detect: register `tick_q` <= `tick_level` every cycle. `tick` = `tick_level & ~tick_q`. A falling edge does nothing.
- `tick_q` updates even while `run`=0, so a rising edge that occurs while paused is lost, not queued.
- LFSR: Fibonacci, shifts left, new LSB = q[7]^q[5]^q[4]^q[3]. It advances only on a LOAD tick.
- The FSM advances only when `tick` & `run`. `bitcnt` is 4 bits.
- LOAD state:
  - `pattern` <= `lfsr[WIDTH-1:0]`. If that value is all ones, bit 0 is forced to 0 so the player always has a free lane.
  - Emit the pattern MSB, pulse `load_pulse`, advance the LFSR.
  - `bitcnt` <= WIDTH-1. Go to EMIT, or to GAP if WIDTH=1.
- EMIT state:
  - Emit `pattern[bitcnt-1]` and decrement `bitcnt`.
  - When the emitted index is 0, `bitcnt` <= GAP and go to GAP. If GAP=0, increment `rows_fed` and go to LOAD instead.
- GAP state:
  - Emit 0 and decrement `bitcnt`.
  - When `bitcnt` reaches 0 after the decrement, increment `rows_fed` and go to LOAD.
- Every emission sets `shift_pulse`=1 for exactly one cycle. `serial_out` holds its last value between pulses.
- `rows_fed` wraps from 127 to 0.
- `run` falling mid-pattern pauses the FSM in place. Resuming continues at the same bit index with no duplicated or skipped bits.

## Timing
- Reset values:
  - FSM state: LOAD.
  - `lfsr`: SEED.
  - `tick_q`: 0.
  - `bitcnt`: 0.
  - `pattern`: 0.
  - `serial_out`, `shift_pulse`, `load_pulse`: 0.
  - `rows_fed`: 0.
- Latency: if `tick_level` is sampled 1 at edge k with `tick_q`=0, then `shift_pulse`/`load_pulse`/`serial_out`/`pattern` are registered at edge k and visible from k until k+1.
- One bit is emitted per tick. A row spans WIDTH+GAP ticks.
- Reset asserted mid-operation clears everything asynchronously and discards the partial row. `shift_pulse` drops immediately.
- After reset releases, the first emission needs a fresh rising edge. If `tick_level` is already 1 when reset releases, no emission occurs until after a 0 has been sampled.

## Structure
- Shared package holds:
  - FSM encoding: ST_LOAD=2'd0, ST_EMIT=2'd1, ST_GAP=2'd2.
  - LFSR tap constant: 8'hB8, i.e. bits 7, 5, 4, 3.
  - Default SEED.
- One sub-module, `rise_pulse`: `INPUTCLOCK`, `reset_n`, `level` in, `pulse` out. The top level instantiates it.
- Everything else lives in the top level: FSM, LFSR, counters and output registers.

## Test plan
- Reset with defaults, 11 rising ticks with `run`=1 → `load_pulse` on tick 1 with `pattern`=7'h25; `serial_out` sequence 0,1,0,0,1,0,1,0,0,0,0; then `rows_fed`=1.
- Continue to tick 12 → `load_pulse`, `pattern`=7'h4A, first bit 1.
- SEED=8'h7F, first tick → `pattern`=7'h7E, because bit 0 is forced clear.
- `run`=0 after the 3rd emitted bit, 5 ticks pass, then `run`=1 → no `shift_pulse` while paused; the next bit is bit index 3 of the same pattern.
- Reset asserted mid-gap while `shift_pulse`=1 → all outputs read 0 in the same cycle; the next rising tick loads 7'h25 again.
- Run 128 full rows → `rows_fed` wraps to 0. Hold `tick_level` high for many cycles → exactly one `shift_pulse` per rising edge.

Source files
------------

// File: rtl/obstacle_row_feeder_pkg.sv
// Shared types and constants for the obstacle row feeder.
// FSM encoding, LFSR taps, default seed, LFSR step helper.
package obstacle_row_feeder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Fibonacci step: shift left, feedback from bits 7,5,4,3.
  function automatic logic [7:0] lfsr_step(
    input logic [7:0] q
  );
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obstacle_row_feeder_rise_pulse.sv
// Rising-edge detector for the rate divider square wave.
// Ports: INPUTCLOCK, reset_n (async, active-high), level in, pulse out.
module rise_pulse (
  input  logic INPUTCLOCK,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic tick_q;
  logic armed;

  // armed blocks a level that was already high when reset released
  // from counting as an edge until a 0 has been sampled.
  always_ff @(posedge INPUTCLOCK or posedge reset_n) begin
    if (reset_n) begin
      tick_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      tick_q <= level;
      armed  <= armed | ~level;
    end
  end

  assign pulse = level & ~tick_q & armed;

endmodule

// File: rtl/obstacle_row_feeder.sv
// Serial obstacle pattern source: LFSR rows, then zero gap bits.
// Ports: INPUTCLOCK, reset_n, run, tick_level in; serial bit/strobes out.
module obstacle_row_feeder
  import obstacle_row_feeder_pkg::*;
#(
  parameter int         WIDTH = 7,
  parameter int         GAP   = 4,
  parameter logic [7:0] SEED  = DEFAULT_SEED
) (
  input  logic             INPUTCLOCK,
  input  logic             reset_n,
  input  logic             run,
  input  logic             tick_level,
  output logic             serial_out,
  output logic             shift_pulse,
  output logic             load_pulse,
  output logic [WIDTH-1:0] pattern,
  output logic [6:0]       rows_fed
);

  localparam logic [3:0] W_LAST = 4'(WIDTH - 1);
  localparam logic [3:0] G_CNT  = 4'(GAP);

  state_t           state;
  logic [7:0]       lfsr;
  logic [3:0]       bitcnt;
  logic             tick;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] shifted;
  logic [3:0]       bit_idx;

  rise_pulse u_rise (
    .INPUTCLOCK (INPUTCLOCK),
    .reset_n    (reset_n),
    .level      (tick_level),
    .pulse      (tick)
  );

  // An all-ones row would block every lane; clear bit 0.
  always_comb begin
    cand = lfsr[WIDTH-1:0];
    if (&cand) cand[0] = 1'b0;
  end

  assign bit_idx = bitcnt - 4'd1;
  assign shifted = pattern >> bit_idx;

  always_ff @(posedge INPUTCLOCK or posedge reset_n) begin
    if (reset_n) begin
      state       <= ST_LOAD;
      lfsr        <= SEED;
      bitcnt      <= 4'd0;
      pattern     <= '0;
      serial_out  <= 1'b0;
      shift_pulse <= 1'b0;
      load_pulse  <= 1'b0;
      rows_fed    <= 7'd0;
    end else begin
      shift_pulse <= 1'b0;
      load_pulse  <= 1'b0;
      if (tick && run) begin
        shift_pulse <= 1'b1;
        unique case (state)
          ST_LOAD: begin
            pattern    <= cand;
            serial_out <= cand[WIDTH-1];
            load_pulse <= 1'b1;
            lfsr       <= lfsr_step(lfsr);
            if (WIDTH == 1) begin
              bitcnt <= G_CNT;
              if (GAP == 0) begin
                rows_fed <= rows_fed + 7'd1;
                state    <= ST_LOAD;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              bitcnt <= W_LAST;
              state  <= ST_EMIT;
            end
          end
          ST_EMIT: begin
            serial_out <= shifted[0];
            if (bitcnt == 4'd1) begin
              bitcnt <= G_CNT;
              if (GAP == 0) begin
                rows_fed <= rows_fed + 7'd1;
                state    <= ST_LOAD;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              bitcnt <= bit_idx;
            end
          end
          ST_GAP: begin
            serial_out <= 1'b0;
            bitcnt     <= bit_idx;
            if (bitcnt == 4'd1) begin
              rows_fed <= rows_fed + 7'd1;
              state    <= ST_LOAD;
            end
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_row_feeder.sv
// Testbench for obstacle_row_feeder against a row-level model.
// Drives ticks, pauses and resets; prints one summary line.
module tb_obstacle_row_feeder;

  localparam int W = 7;
  localparam int G = 4;
  localparam int R = W + G;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b1;
  logic         tick_level = 1'b0;
  logic         serial_out, shift_pulse, load_pulse;
  logic [W-1:0] pattern;
  logic [6:0]   rows_fed;
  logic         so2, sp2, lp2;
  logic [W-1:0] pattern2;
  logic [6:0]   rows2;

  int checks = 0;
  int failures = 0;

  logic [7:0]   m_lfsr;
  logic [W-1:0] m_pat;
  int           m_pos;
  logic [6:0]   m_rows;

  logic         c_sp, c_so, c_lp;
  logic [W-1:0] c_pat, c_pat2;
  logic [6:0]   c_rows;
  int           extra;

  logic         e_b, e_l;
  logic [W-1:0] e_p;
  logic [6:0]   e_r;

  obstacle_row_feeder #(.WIDTH(W), .GAP(G)) dut (
    .INPUTCLOCK  (clk),
    .reset_n     (rst),
    .run         (run),
    .tick_level  (tick_level),
    .serial_out  (serial_out),
    .shift_pulse (shift_pulse),
    .load_pulse  (load_pulse),
    .pattern     (pattern),
    .rows_fed    (rows_fed)
  );

  obstacle_row_feeder #(.WIDTH(W), .GAP(G), .SEED(8'h7F)) dut2 (
    .INPUTCLOCK  (clk),
    .reset_n     (rst),
    .run         (run),
    .tick_level  (tick_level),
    .serial_out  (so2),
    .shift_pulse (sp2),
    .load_pulse  (lp2),
    .pattern     (pattern2),
    .rows_fed    (rows2)
  );

  always #5 clk = ~clk;

  task automatic model_init();
    m_lfsr = 8'hA5;
    m_pat  = '0;
    m_pos  = 0;
    m_rows = 7'd0;
  endtask

  // One emitted bit: position within a row of W pattern bits + G zeros.
  task automatic model_emit();
    e_l = 1'b0;
    if (m_pos == 0) begin
      m_pat = m_lfsr[W-1:0];
      if (m_pat == {W{1'b1}}) m_pat[0] = 1'b0;
      m_lfsr = {m_lfsr[6:0],
                m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      e_l = 1'b1;
    end
    e_b = (m_pos < W) ? m_pat[W-1-m_pos] : 1'b0;
    m_pos++;
    if (m_pos == R) begin
      m_pos = 0;
      m_rows = m_rows + 7'd1;
    end
    e_p = m_pat;
    e_r = m_rows;
  endtask

  task automatic tick(input int hi, input int lo);
    tick_level = 1'b1;
    @(posedge clk); #1;
    c_sp = shift_pulse;
    c_so = serial_out;
    c_lp = load_pulse;
    c_pat = pattern;
    c_pat2 = pattern2;
    c_rows = rows_fed;
    extra = 0;
    for (int i = 1; i < hi; i++) begin
      @(posedge clk); #1;
      extra += int'(shift_pulse);
    end
    tick_level = 1'b0;
    for (int i = 0; i < lo; i++) begin
      @(posedge clk); #1;
      extra += int'(shift_pulse);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_level = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    model_init();
  endtask

  task automatic check_emit(input string name);
    model_emit();
    checks++;
    if ({c_sp, c_so, c_lp, c_pat, c_rows, extra}
        !== {1'b1, e_b, e_l, e_p, e_r, 32'd0}) begin
      failures++;
      $display("FAIL %s got sp=%b so=%b lp=%b pat=%h rows=%0d extra=%0d want so=%b lp=%b pat=%h rows=%0d",
               name, c_sp, c_so, c_lp, c_pat, c_rows, extra,
               e_b, e_l, e_p, e_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_level = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({serial_out, shift_pulse, load_pulse, pattern, rows_fed} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 0",
               {serial_out, shift_pulse, load_pulse, pattern, rows_fed});
    end
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      extra += int'(shift_pulse);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL high_at_release got %0d pulses want 0", extra);
    end
    tick_level = 1'b0;
    @(posedge clk); #1;
    model_init();
  endtask

  task automatic test_first_row();
    logic [10:0] seq;
    logic [10:0] want_seq;
    want_seq = 11'b01001010000;
    for (int t = 0; t < R; t++) begin
      tick(1, 1);
      seq[10-t] = c_so;
      if (t == 0) begin
        checks++;
        if (c_lp !== 1'b1 || c_pat !== 7'h25) begin
          failures++;
          $display("FAIL first_load got lp=%b pat=%h want 1 25", c_lp, c_pat);
        end
        checks++;
        if (c_pat2 !== 7'h7E) begin
          failures++;
          $display("FAIL seed7f_pattern got %h want 7e", c_pat2);
        end
      end
      check_emit("first_row");
    end
    checks++;
    if (seq !== want_seq) begin
      failures++;
      $display("FAIL first_row_bits got %b want %b", seq, want_seq);
    end
    checks++;
    if (rows_fed !== 7'd1) begin
      failures++;
      $display("FAIL rows_after_row1 got %0d want 1", rows_fed);
    end
  endtask

  task automatic test_second_load();
    tick(2, 2);
    checks++;
    if ({c_lp, c_pat, c_so} !== {1'b1, 7'h4A, 1'b1}) begin
      failures++;
      $display("FAIL second_load got lp=%b pat=%h so=%b want 1 4a 1",
               c_lp, c_pat, c_so);
    end
    check_emit("second_load");
  endtask

  task automatic test_pause();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      tick(1, 1);
      check_emit("pre_pause");
    end
    run = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick($urandom_range(1, 3), $urandom_range(1, 3));
      checks++;
      if (c_sp !== 1'b0 || extra !== 0 || c_pat !== 7'h25) begin
        failures++;
        $display("FAIL paused got sp=%b extra=%0d pat=%h want 0 0 25",
                 c_sp, extra, c_pat);
      end
    end
    run = 1'b1;
    tick(1, 1);
    checks++;
    if (c_so !== 1'b0 || c_lp !== 1'b0) begin
      failures++;
      $display("FAIL resume_bit3 got so=%b lp=%b want 0 0", c_so, c_lp);
    end
    check_emit("resume");
    for (int t = 0; t < 3; t++) begin
      tick(1, 1);
      check_emit("after_resume");
    end
  endtask

  task automatic test_reset_mid_gap();
    while (m_pos != W + 2) begin
      tick(1, 1);
      check_emit("to_gap");
    end
    tick_level = 1'b1;
    @(posedge clk); #1;
    model_emit();
    checks++;
    if (shift_pulse !== 1'b1 || serial_out !== 1'b0) begin
      failures++;
      $display("FAIL gap_bit got sp=%b so=%b want 1 0", shift_pulse, serial_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({serial_out, shift_pulse, load_pulse, pattern, rows_fed} !== '0) begin
      failures++;
      $display("FAIL async_reset got %b want 0",
               {serial_out, shift_pulse, load_pulse, pattern, rows_fed});
    end
    tick_level = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    model_init();
    tick(1, 1);
    checks++;
    if (c_lp !== 1'b1 || c_pat !== 7'h25) begin
      failures++;
      $display("FAIL reload_after_reset got lp=%b pat=%h want 1 25", c_lp, c_pat);
    end
    check_emit("post_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      run = ($urandom_range(0, 4) != 0);
      tick($urandom_range(1, 6), $urandom_range(1, 4));
      if (run) begin
        check_emit("random");
      end else begin
        checks++;
        if (c_sp !== 1'b0 || extra !== 0 || c_pat !== e_p) begin
          failures++;
          $display("FAIL random_paused got sp=%b extra=%0d pat=%h want 0 0 %h",
                   c_sp, extra, c_pat, e_p);
        end
      end
    end
    run = 1'b1;
  endtask

  task automatic test_hold_high();
    for (int t = 0; t < 6; t++) begin
      tick(25, 1);
      check_emit("hold_high");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int t = 0; t < 128 * R; t++) begin
      tick(1, 1);
      check_emit("wrap");
    end
    checks++;
    if (rows_fed !== 7'd0) begin
      failures++;
      $display("FAIL rows_wrap got %0d want 0", rows_fed);
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_second_load();
    test_pause();
    test_reset_mid_gap();
    test_random();
    test_hold_high();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
